// File: rtl/bin2bcd_seq_if.sv
// ---------------------------------------------------------------------------
// bin2bcd_seq_if
//   Handshake bundle for the sequential binary-to-BCD converter.
//   Input channel : in_valid / in_ready / in_data
//   Output channel: out_valid / out_ready / out_bcd / out_sign / out_ovf
//   Optional      : out_blank (leading-zero blanking, BIN2BCD_LZB_EN defined)
//   Modports:
//     master - upstream producer and downstream consumer side
//     slave  - converter side
// ---------------------------------------------------------------------------
interface bin2bcd_seq_if #(
    parameter int WIDTH  = 16,
    parameter int DIGITS = 5
);
    logic                  in_valid;
    logic                  in_ready;
    logic [WIDTH-1:0]      in_data;
    logic                  out_valid;
    logic                  out_ready;
    logic [4*DIGITS-1:0]   out_bcd;
    logic                  out_sign;
    logic                  out_ovf;
`ifdef BIN2BCD_LZB_EN
    logic [DIGITS-1:0]     out_blank;

    modport master (
        output in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_bcd, out_sign, out_ovf, out_blank
    );

    modport slave (
        input  in_valid, in_data, out_ready,
        output in_ready, out_valid, out_bcd, out_sign, out_ovf, out_blank
    );
`else
    modport master (
        output in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_bcd, out_sign, out_ovf
    );

    modport slave (
        input  in_valid, in_data, out_ready,
        output in_ready, out_valid, out_bcd, out_sign, out_ovf
    );
`endif
endinterface

// File: rtl/bin2bcd_seq.sv
// ---------------------------------------------------------------------------
// bin2bcd_seq
//   Sequential binary-to-BCD converter using shift-and-add-3, one input bit
//   per clock. Accepts a WIDTH-bit word (two's complement when SIGNED=1, the
//   magnitude is converted) and returns DIGITS packed BCD digits with sign and
//   overflow flags. Overflow means value >= 10^DIGITS; out_bcd then holds the
//   value modulo 10^DIGITS.
//
//   Ports:
//     clk    - rising-edge clock
//     rst_n  - synchronous active-low reset
//     bus    - bin2bcd_seq_if.slave handshake bundle (in_*/out_* channels)
//     busy   - high while converting
//
//   Optional feature (macro BIN2BCD_LZB_EN): registered leading-zero blanking
//   flags on bus.out_blank; bit i (i>=1) is set when digit i and all higher
//   digits are zero, bit 0 is always 0.
// ---------------------------------------------------------------------------
module bin2bcd_seq #(
    parameter int WIDTH  = 16,
    parameter int DIGITS = 5,
    parameter bit SIGNED = 1'b1
) (
    input  logic           clk,
    input  logic           rst_n,
    bin2bcd_seq_if.slave   bus,
    output logic           busy
);

    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_CONV,
        S_DONE
    } state_t;

    state_t                r_state;
    state_t                w_next;

    logic [CW-1:0]         r_count;
    logic [WIDTH-1:0]      r_mag;
    logic [4*DIGITS-1:0]   r_bcd;
    logic                  r_sign;
    logic                  r_ovf;

    logic [4*DIGITS-1:0]   r_out_bcd;
    logic                  r_out_sign;
    logic                  r_out_ovf;

    logic                  w_accept;
    logic                  w_finish;
    logic [WIDTH-1:0]      w_mag_in;
    logic                  w_sign_in;
    logic [4*DIGITS-1:0]   w_bcd_adj;
    logic [4*DIGITS-1:0]   w_bcd_shift;
    logic [WIDTH-1:0]      w_mag_shift;
    logic                  w_carry;

`ifdef BIN2BCD_LZB_EN
    logic [DIGITS-1:0]     r_out_blank;
    logic [DIGITS-1:0]     w_blank;
    logic                  w_zero_above;
`endif

    assign w_accept = bus.in_valid && (r_state == S_IDLE);
    // The count==0 cycle in CONV is the result-commit cycle (no shift).
    assign w_finish = (r_state == S_CONV) && (r_count == '0);

    // Two's complement negate in WIDTH bits: the most negative input maps to
    // 2^(WIDTH-1), which still fits as an unsigned magnitude.
    assign w_sign_in = SIGNED ? bus.in_data[WIDTH-1] : 1'b0;
    assign w_mag_in  = w_sign_in ? -bus.in_data : bus.in_data;

    // Add 3 to every digit >= 5 before the shift so it carries correctly.
    always_comb begin
        w_bcd_adj = r_bcd;
        for (int unsigned i = 0; i < DIGITS; i++) begin
            if (r_bcd[4*i +: 4] >= 4'd5) begin
                w_bcd_adj[4*i +: 4] = r_bcd[4*i +: 4] + 4'd3;
            end
        end
    end

    // Bit leaving the top digit is lost from out_bcd and recorded as overflow.
    assign w_carry     = w_bcd_adj[4*DIGITS-1];
    assign w_bcd_shift = {w_bcd_adj[4*DIGITS-2:0], r_mag[WIDTH-1]};
    assign w_mag_shift = {r_mag[WIDTH-2:0], 1'b0};

`ifdef BIN2BCD_LZB_EN
    // Walk from the top digit down, accumulating "everything above is zero".
    always_comb begin
        w_blank      = '0;
        w_zero_above = 1'b1;
        for (int unsigned i = DIGITS - 1; i >= 1; i--) begin
            w_zero_above = w_zero_above && (r_bcd[4*i +: 4] == 4'd0);
            w_blank[i]   = w_zero_above;
        end
    end
`endif

    // State register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state logic
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (bus.in_valid)   w_next = S_CONV;
            S_CONV:  if (r_count == '0)  w_next = S_DONE;
            S_DONE:  if (bus.out_ready)  w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    // Datapath: working shift registers and the result registers
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_count    <= '0;
            r_mag      <= '0;
            r_bcd      <= '0;
            r_sign     <= 1'b0;
            r_ovf      <= 1'b0;
            r_out_bcd  <= '0;
            r_out_sign <= 1'b0;
            r_out_ovf  <= 1'b0;
`ifdef BIN2BCD_LZB_EN
            r_out_blank <= '0;
`endif
        end else begin
            if (w_accept) begin
                r_mag   <= w_mag_in;
                r_bcd   <= '0;
                r_sign  <= w_sign_in;
                r_ovf   <= 1'b0;
                r_count <= CW'(WIDTH);
            end else if ((r_state == S_CONV) && (r_count != '0)) begin
                r_bcd   <= w_bcd_shift;
                r_mag   <= w_mag_shift;
                r_ovf   <= r_ovf | w_carry;
                r_count <= r_count - CW'(1);
            end

            if (w_finish) begin
                r_out_bcd  <= r_bcd;
                r_out_sign <= r_sign;
                r_out_ovf  <= r_ovf;
`ifdef BIN2BCD_LZB_EN
                r_out_blank <= w_blank;
`endif
            end
        end
    end

    // Output logic
    always_comb begin
        bus.in_ready  = (r_state == S_IDLE);
        bus.out_valid = (r_state == S_DONE);
        busy          = (r_state == S_CONV);
        bus.out_bcd   = r_out_bcd;
        bus.out_sign  = r_out_sign;
        bus.out_ovf   = r_out_ovf;
`ifdef BIN2BCD_LZB_EN
        bus.out_blank = r_out_blank;
`endif
    end

endmodule

// File: tb/tb_bin2bcd_seq.sv
// ---------------------------------------------------------------------------
// tb_bin2bcd_seq
//   Three converters share one stimulus stream:
//     A: WIDTH=16 DIGITS=5 SIGNED=1
//     B: WIDTH=16 DIGITS=5 SIGNED=0
//     C: WIDTH=16 DIGITS=3 SIGNED=0 (overflow cases)
//   Expected values come from a fixed vector table and from an arithmetic
//   reference model (integer divide/modulo).
// ---------------------------------------------------------------------------
module tb_bin2bcd_seq;

    localparam int W = 16;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        out_ready = 1'b0;
    logic [15:0] in_data = '0;
    logic        busyA, busyB, busyC;

    int n_checks = 0;
    int n_fail   = 0;

    bin2bcd_seq_if #(.WIDTH(16), .DIGITS(5)) ifA ();
    bin2bcd_seq_if #(.WIDTH(16), .DIGITS(5)) ifB ();
    bin2bcd_seq_if #(.WIDTH(16), .DIGITS(3)) ifC ();

    assign ifA.in_valid  = in_valid;
    assign ifA.in_data   = in_data;
    assign ifA.out_ready = out_ready;
    assign ifB.in_valid  = in_valid;
    assign ifB.in_data   = in_data;
    assign ifB.out_ready = out_ready;
    assign ifC.in_valid  = in_valid;
    assign ifC.in_data   = in_data;
    assign ifC.out_ready = out_ready;

    bin2bcd_seq #(.WIDTH(16), .DIGITS(5), .SIGNED(1'b1)) u_dutA (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (ifA),
        .busy  (busyA)
    );

    bin2bcd_seq #(.WIDTH(16), .DIGITS(5), .SIGNED(1'b0)) u_dutB (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (ifB),
        .busy  (busyB)
    );

    bin2bcd_seq #(.WIDTH(16), .DIGITS(3), .SIGNED(1'b0)) u_dutC (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (ifC),
        .busy  (busyC)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] din;
        logic [19:0] a_bcd;
        logic        a_sign;
        logic [19:0] b_bcd;
        logic [11:0] c_bcd;
        logic        c_ovf;
    } vec_t;

    vec_t vecs[8];

    task automatic check(input string name, input longint act, input longint exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Reference model: plain integer arithmetic on the input value.
    function automatic void model(input logic [15:0] d, input int digits, input bit sgn,
                                  output longint bcd, output longint s,
                                  output longint ovf, output longint blank);
        longint v, lim, r, p;
        v = longint'(d);
        s = 0;
        if (sgn && d[15]) begin
            v = 65536 - longint'(d);
            s = 1;
        end
        lim = 1;
        for (int i = 0; i < digits; i++) lim = lim * 10;
        ovf   = (v >= lim) ? 1 : 0;
        r     = v % lim;
        bcd   = 0;
        blank = 0;
        p     = 10;
        for (int i = 1; i < digits; i++) begin
            if (r < p) blank = blank | (longint'(1) << i);
            p = p * 10;
        end
        for (int i = 0; i < digits; i++) begin
            bcd = bcd | ((r % 10) << (4 * i));
            r   = r / 10;
        end
    endfunction

    task automatic check_all(input logic [15:0] d);
        longint b, s, o, bl;
        model(d, 5, 1'b1, b, s, o, bl);
        check("A_bcd", longint'(ifA.out_bcd), b);
        check("A_sign", longint'(ifA.out_sign), s);
        check("A_ovf", longint'(ifA.out_ovf), o);
`ifdef BIN2BCD_LZB_EN
        check("A_blank", longint'(ifA.out_blank), bl);
`endif
        model(d, 5, 1'b0, b, s, o, bl);
        check("B_bcd", longint'(ifB.out_bcd), b);
        check("B_sign", longint'(ifB.out_sign), s);
        check("B_ovf", longint'(ifB.out_ovf), o);
        model(d, 3, 1'b0, b, s, o, bl);
        check("C_bcd", longint'(ifC.out_bcd), b);
        check("C_ovf", longint'(ifC.out_ovf), o);
`ifdef BIN2BCD_LZB_EN
        check("C_blank", longint'(ifC.out_blank), bl);
`endif
    endtask

    // One full transaction, entered and left at a falling edge.
    // hold: cycles out_ready stays low after out_valid; poke: drive in_valid meanwhile.
    task automatic convert(input logic [15:0] d, input int hold, input bit poke);
        int k;
        logic [19:0] held;
        in_valid = 1'b1;
        in_data  = d;
        k = 0;
        while (!ifA.in_ready && k < 50) begin
            @(negedge clk);
            k++;
        end
        check("in_ready_before_accept", longint'(ifA.in_ready), 1);
        @(negedge clk);
        in_valid = 1'b0;
        in_data  = 16'($urandom);
        check("busy_after_accept", longint'(busyA), 1);
        check("in_ready_in_conv", longint'(ifA.in_ready), 0);
        k = 0;
        while (!ifA.out_valid && k < 40) begin
            @(negedge clk);
            k++;
        end
        check("latency", longint'(k), longint'(W + 1));
        check("B_valid", longint'(ifB.out_valid), 1);
        check("C_valid", longint'(ifC.out_valid), 1);
        check_all(d);
        held = ifA.out_bcd;
        for (int h = 0; h < hold; h++) begin
            if (poke) begin
                in_valid = 1'b1;
                in_data  = 16'($urandom);
            end
            @(negedge clk);
            check("hold_valid", longint'(ifA.out_valid), 1);
            check("hold_in_ready", longint'(ifA.in_ready), 0);
            check("hold_bcd", longint'(ifA.out_bcd), longint'(held));
        end
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        check("valid_dropped", longint'(ifA.out_valid), 0);
        check("in_ready_back", longint'(ifA.in_ready), 1);
        check("busy_idle", longint'(busyA), 0);
        check("idle_hold_bcd", longint'(ifA.out_bcd), longint'(held));
        in_valid = 1'b0;
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, "_in_ready"}, longint'(ifA.in_ready), 1);
        check({tag, "_out_valid"}, longint'(ifA.out_valid), 0);
        check({tag, "_busy"}, longint'(busyA), 0);
        check({tag, "_A_bcd"}, longint'(ifA.out_bcd), 0);
        check({tag, "_A_sign"}, longint'(ifA.out_sign), 0);
        check({tag, "_A_ovf"}, longint'(ifA.out_ovf), 0);
        check({tag, "_C_bcd"}, longint'(ifC.out_bcd), 0);
        check({tag, "_C_ovf"}, longint'(ifC.out_ovf), 0);
    endtask

    initial begin
        int k;
        vecs[0] = '{16'h7FFF, 20'h32767, 1'b0, 20'h32767, 12'h767, 1'b1};
        vecs[1] = '{16'h8000, 20'h32768, 1'b1, 20'h32768, 12'h768, 1'b1};
        vecs[2] = '{16'hFFFF, 20'h00001, 1'b1, 20'h65535, 12'h535, 1'b1};
        vecs[3] = '{16'h0000, 20'h00000, 1'b0, 20'h00000, 12'h000, 1'b0};
        vecs[4] = '{16'd1234, 20'h01234, 1'b0, 20'h01234, 12'h234, 1'b1};
        vecs[5] = '{16'd999,  20'h00999, 1'b0, 20'h00999, 12'h999, 1'b0};
        vecs[6] = '{16'd1000, 20'h01000, 1'b0, 20'h01000, 12'h000, 1'b1};
        vecs[7] = '{16'hFFD6, 20'h00042, 1'b1, 20'h65494, 12'h494, 1'b1};

        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        check_reset_state("reset");
        rst_n = 1'b1;
        @(negedge clk);

        // Fixed vectors; results must still be held in IDLE after the handshake.
        for (int i = 0; i < 8; i++) begin
            convert(vecs[i].din, 0, 1'b0);
            check("tab_A_bcd", longint'(ifA.out_bcd), longint'(vecs[i].a_bcd));
            check("tab_A_sign", longint'(ifA.out_sign), longint'(vecs[i].a_sign));
            check("tab_A_ovf", longint'(ifA.out_ovf), 0);
            check("tab_B_bcd", longint'(ifB.out_bcd), longint'(vecs[i].b_bcd));
            check("tab_B_sign", longint'(ifB.out_sign), 0);
            check("tab_C_bcd", longint'(ifC.out_bcd), longint'(vecs[i].c_bcd));
            check("tab_C_ovf", longint'(ifC.out_ovf), longint'(vecs[i].c_ovf));
        end

        // Back-pressure: 10 stalled cycles with a competing in_valid.
        convert(16'd4321, 10, 1'b1);

        // Reset during conversion, five cycles in.
        in_valid = 1'b1;
        in_data  = 16'd777;
        @(negedge clk);
        in_valid = 1'b0;
        repeat (5) @(negedge clk);
        check("midconv_busy", longint'(busyA), 1);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        check_reset_state("rst_conv");

        convert(16'd42, 0, 1'b0);
        check("after_rst_A_bcd", longint'(ifA.out_bcd), longint'(20'h00042));
`ifdef BIN2BCD_LZB_EN
        check("after_rst_A_blank", longint'(ifA.out_blank), longint'(5'b11100));
`endif

        // Reset while the result is waiting in DONE.
        in_valid = 1'b1;
        in_data  = 16'hFFFF;
        @(negedge clk);
        in_valid = 1'b0;
        k = 0;
        while (!ifA.out_valid && k < 40) begin
            @(negedge clk);
            k++;
        end
        check("done_before_rst", longint'(ifA.out_valid), 1);
        check("done_bcd_before_rst", longint'(ifA.out_bcd), longint'(20'h00001));
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        check_reset_state("rst_done");

        // Random operands with random back-pressure.
        repeat (40) begin
            convert(16'($urandom), int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #300000;
        $display("FAIL watchdog: time limit reached, got no end of test, expected completion");
        $fatal(1, "watchdog");
    end

endmodule
